// File: rtl/por_reset_sequencer_pkg.sv
// Shared types and constants for the POR reset sequencer: FSM state encoding,
// default parameter values and the shared counter width helper.
package por_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_FILTER  = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_SWRST   = 3'd4
    } state_t;

    localparam int DEF_NUM_DOMAINS   = 4;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_FILTER_CYCLES = 16;
    localparam int DEF_STAGE_GAP     = 8;

    // One counter serves the POR filter, the staggered release and the SW hold.
    function automatic int cnt_width(input int filt, input int nd, input int gap);
        int m;
        m = (filt > nd * gap) ? filt : nd * gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/por_reset_sequencer_sync.sv
// Synchronizer for the active-low POR: asserts (clears) asynchronously on rst or
// por_n_i low, deasserts synchronously after STAGES clock edges.
module por_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic por_n_i,
    output logic por_sync_o
);

    logic              clr;
    logic [STAGES-1:0] sync_q;

    assign clr = rst | ~por_n_i;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) sync_q <= '0;
        else     sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end

    assign por_sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: filters the synchronized POR and releases domain
// resets in staggered order. Define POR_SEQ_SW_RST_EN to enable software reset.
module por_reset_sequencer
    import por_seq_pkg::*;
#(
    parameter int NUM_DOMAINS   = DEF_NUM_DOMAINS,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int STAGE_GAP     = DEF_STAGE_GAP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   por_n_i,
    input  logic                   sw_rst_req_i,
    output logic [NUM_DOMAINS-1:0] domain_rst_n_o,
    output logic                   seq_done_o,
    output logic                   por_event_o,
    output logic [2:0]             state_o
);

    localparam int CNT_W = cnt_width(FILTER_CYCLES, NUM_DOMAINS, STAGE_GAP);

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q, cnt_inc;
    logic [NUM_DOMAINS-1:0] dom_q, rel_hit;
    logic                   done_q, ev_q;
    logic                   por_sync, sw_req;
    logic                   filt_done, gap_done, last_rel, go_rel, active;

`ifdef POR_SEQ_SW_RST_EN
    assign sw_req = sw_rst_req_i;
`else
    logic unused_sw_req;
    assign unused_sw_req = sw_rst_req_i;
    assign sw_req        = 1'b0;
`endif

    por_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .por_n_i   (por_n_i),
        .por_sync_o(por_sync)
    );

    // Transitions fire on the edge where cnt reaches its target, hence cnt_inc.
    always_comb begin
        cnt_inc   = cnt_q + CNT_W'(1);
        filt_done = (cnt_inc == CNT_W'(FILTER_CYCLES));
        gap_done  = (cnt_inc == CNT_W'(STAGE_GAP));
        last_rel  = (cnt_inc == CNT_W'((NUM_DOMAINS - 1) * STAGE_GAP));
        rel_hit   = '0;
        for (int k = 0; k < NUM_DOMAINS; k++)
            rel_hit[k] = (cnt_inc == CNT_W'(k * STAGE_GAP));
        active = (state_q == ST_RELEASE) || (state_q == ST_RUN) || (state_q == ST_SWRST);
        go_rel = por_sync &&
                 ((((state_q == ST_HOLD) || (state_q == ST_FILTER)) && filt_done) ||
                  ((state_q == ST_SWRST) && gap_done));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            dom_q   <= '0;
            done_q  <= 1'b0;
            ev_q    <= 1'b0;
        end else begin
            ev_q <= 1'b0;
            if (!por_sync && active) begin
                state_q <= ST_HOLD;
                cnt_q   <= '0;
                dom_q   <= '0;
                done_q  <= 1'b0;
                ev_q    <= 1'b1;
            end else if (go_rel) begin
                cnt_q <= '0;
                dom_q <= NUM_DOMAINS'(1);
                if (NUM_DOMAINS == 1) begin
                    state_q <= ST_RUN;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= ST_RELEASE;
                end
            end else begin
                case (state_q)
                    ST_HOLD, ST_FILTER: begin
                        if (por_sync) begin
                            state_q <= ST_FILTER;
                            cnt_q   <= cnt_inc;
                        end else begin
                            state_q <= ST_HOLD;
                            cnt_q   <= '0;
                        end
                    end
                    ST_RELEASE: begin
                        cnt_q <= cnt_inc;
                        dom_q <= dom_q | rel_hit;
                        if (last_rel) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (sw_req) begin
                            state_q <= ST_SWRST;
                            cnt_q   <= '0;
                            dom_q   <= '0;
                            done_q  <= 1'b0;
                        end
                    end
                    ST_SWRST: cnt_q <= cnt_inc;
                    default: begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                        dom_q   <= '0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign domain_rst_n_o = dom_q;
    assign seq_done_o     = done_q;
    assign por_event_o    = ev_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Directed scoreboard bench for por_reset_sequencer (default parameters);
// expectations follow POR_SEQ_SW_RST_EN when it is defined for the build.
module tb_por_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst, por_n_i, sw_rst_req_i;
    logic [3:0] domain_rst_n_o;
    logic       seq_done_o, por_event_o;
    logic [2:0] state_o;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    typedef struct {
        int         at;
        logic [3:0] dom;
        logic       done;
        logic       ev;
        logic [2:0] st;
        string      tag;
    } exp_t;

    exp_t sb[$];

    por_reset_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .por_n_i       (por_n_i),
        .sw_rst_req_i  (sw_rst_req_i),
        .domain_rst_n_o(domain_rst_n_o),
        .seq_done_o    (seq_done_o),
        .por_event_o   (por_event_o),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] d, input logic dn,
                       input logic ev, input logic [2:0] st);
        logic [8:0] obs, exp_v;
        obs   = {domain_rst_n_o, seq_done_o, por_event_o, state_o};
        exp_v = {d, dn, ev, st};
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed dom=%b done=%b ev=%b st=%0d, expected dom=%b done=%b ev=%b st=%0d",
                   tag, edge_n, obs[8:5], obs[4], obs[3], obs[2:0], d, dn, ev, st);
        end
    endtask

    task automatic expect_at(input int at, input logic [3:0] d, input logic dn,
                             input logic ev, input logic [2:0] st, input string tag);
        exp_t e;
        e.at = at; e.dom = d; e.done = dn; e.ev = ev; e.st = st; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        edge_n++;
        #1;
        while (sb.size() > 0 && sb[0].at <= edge_n) begin
            e = sb.pop_front();
            chk(e.tag, e.dom, e.done, e.ev, e.st);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Full power-up sequence; edge 1 is the first edge with por_n_i high.
    task automatic seq(input logic ev_first, input int n, input string tag);
        int         b;
        logic [3:0] d;
        logic [2:0] st;
        b = edge_n;
        for (int e = 1; e <= n; e++) begin
            for (int k = 0; k < 4; k++) d[k] = (e >= 18 + 8 * k);
            st = (e <= 2) ? 3'd0 : (e < 18) ? 3'd1 : (e < 42) ? 3'd2 : 3'd3;
            expect_at(b + e, d, (e >= 42), ev_first && (e == 1), st, tag);
        end
        run(n);
    endtask

    initial begin
        int         b;
        logic [3:0] d;
        logic [2:0] st;
        rst = 1'b1; por_n_i = 1'b0; sw_rst_req_i = 1'b0;
        #1;
        chk("reset_state", 4'b0000, 1'b0, 1'b0, 3'd0);
        run(2);
        rst = 1'b0;
        expect_at(edge_n + 1, 4'b0000, 1'b0, 1'b0, 3'd0, "hold_no_por");
        tick();

        por_n_i = 1'b1;
        seq(1'b0, 44, "powerup");

        b = edge_n;
        for (int e = 1; e <= 36; e++) begin
`ifdef POR_SEQ_SW_RST_EN
            for (int k = 0; k < 4; k++) d[k] = (e >= 9 + 8 * k);
            st = (e < 9) ? 3'd4 : (e < 33) ? 3'd2 : 3'd3;
            expect_at(b + e, d, (e >= 33), 1'b0, st, "swrst");
`else
            expect_at(b + e, 4'b1111, 1'b1, 1'b0, 3'd3, "swrst_ignored");
`endif
        end
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        run(35);

        #1 por_n_i = 1'b0;
        #1 por_n_i = 1'b1;
        seq(1'b1, 44, "brownout");

        por_n_i = 1'b0;
        expect_at(edge_n + 1, 4'b0000, 1'b0, 1'b1, 3'd0, "glitch_bo");
        expect_at(edge_n + 2, 4'b0000, 1'b0, 1'b0, 3'd0, "glitch_hold");
        run(2);
        por_n_i = 1'b1;
        b = edge_n;
        for (int e = 1; e <= 10; e++)
            expect_at(b + e, 4'b0000, 1'b0, 1'b0, (e <= 2) ? 3'd0 : 3'd1, "glitch_filter");
        run(10);
        por_n_i = 1'b0;
        expect_at(edge_n + 1, 4'b0000, 1'b0, 1'b0, 3'd0, "glitch_drop");
        tick();
        por_n_i = 1'b1;
        seq(1'b0, 44, "glitch_recover");

        sw_rst_req_i = 1'b1;
        por_n_i      = 1'b0;
        expect_at(edge_n + 1, 4'b0000, 1'b0, 1'b1, 3'd0, "simul_event");
        tick();
        sw_rst_req_i = 1'b0;
        por_n_i      = 1'b1;
        seq(1'b0, 28, "simul_resequence");

        #2 rst = 1'b1;
        #1;
        chk("midseq_rst_async", 4'b0000, 1'b0, 1'b0, 3'd0);
        tick();
        chk("midseq_rst_held", 4'b0000, 1'b0, 1'b0, 3'd0);
        rst = 1'b0;

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d pending, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
